// File: rtl/ahb_sram_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_sram_slave_if
//  Description : AHB-Lite signal bundle between a master/interconnect and
//                the SRAM slave.
//                master modport : drives address/control/write data and
//                                 HREADY (the selected slave's HREADYOUT)
//                slave modport  : drives HRDATA, HREADYOUT, HRESP
//  Revision    : 1.0  initial release
// ============================================================================
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK,
               HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK,
               HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_sram_slave
//  Description : AHB-Lite slave backed by a word-organised SRAM model.
//                Byte/half/word writes with little-endian lane enables,
//                full-word registered reads, programmable wait states and
//                write->read forwarding for zero-wait back-to-back access.
//  Ports       : HCLK     - bus clock
//                HRESETN  - asynchronous active-low reset
//                bus      - ahb_sram_slave_if.slave (address/control/data
//                           in, HRDATA/HREADYOUT/HRESP out)
//  Parameters  : DEPTH       - memory size in 32-bit words (power of two)
//                WAIT_STATES - HREADYOUT-low cycles per data phase (0..15)
//  Options     : AHB_SLV_ERR_EN - when defined, misaligned, oversize and
//                out-of-range transfers get a two-cycle ERROR response;
//                when undefined, addresses are aligned down and wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_sram_slave #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  wire logic           HCLK,
    input  wire logic           HRESETN,
    ahb_sram_slave_if.slave     bus
);

    localparam int         c_AW      = $clog2(DEPTH);
    localparam logic [3:0] c_WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t          r_state, w_next;
    logic [3:0]      r_wcnt, w_wcnt_next;
    logic [c_AW-1:0] r_idx, w_idx, w_rd_idx;
    logic [3:0]      r_lanes, w_lanes;
    logic            r_write;
    logic [31:0]     r_hrdata;
    logic [1:0]      w_size;
    logic            w_accept, w_err, w_rd_read, w_fwd;
    logic [31:0]     w_mem_word, w_rd_word;
    logic [31:0]     mem [DEPTH];

    // Bus-only attributes the slave does not act on.
    logic w_unused;
    assign w_unused = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HADDR};

    // A new address phase is only taken while this slave is showing ready.
    assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] &
                      ((r_state == S_IDLE) | (r_state == S_DATA) | (r_state == S_ERR2));

    // Address decode: oversize is treated as word; the word index drops the
    // low address bits, which aligns halves/words down and wraps high bits.
    always_comb begin
        w_size = (bus.HSIZE > 3'd2) ? 2'd2 : bus.HSIZE[1:0];
        w_idx  = bus.HADDR[c_AW+1:2];
        case (w_size)
            2'd0:    w_lanes = 4'b0001 << bus.HADDR[1:0];
            2'd1:    w_lanes = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            default: w_lanes = 4'b1111;
        endcase
    end

`ifdef AHB_SLV_ERR_EN
    assign w_err = (bus.HSIZE > 3'd2)
                 | ((bus.HSIZE == 3'd1) & bus.HADDR[0])
                 | ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00))
                 | (bus.HADDR[31:c_AW+2] != '0);
`else
    assign w_err = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        w_next      = r_state;
        w_wcnt_next = r_wcnt;
        case (r_state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_next = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_next      = S_WAIT;
                        w_wcnt_next = c_WS_LOAD;
                    end else begin
                        w_next = S_DATA;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_wcnt == 4'd0) begin
                    w_next = S_DATA;
                end else begin
                    w_wcnt_next = r_wcnt - 4'd1;
                end
            end
            S_ERR1:  w_next = S_ERR2;
            default: w_next = S_IDLE;
        endcase
    end

    // Read path. DATA is entered either from WAIT (transfer already
    // captured) or directly from the address phase on the bus. In the direct
    // case a write may be committing to the same word on this very edge, so
    // its lanes are merged in from HWDATA instead of the stale array word.
    always_comb begin
        w_rd_idx   = (r_state == S_WAIT) ? r_idx : w_idx;
        w_rd_read  = (r_state == S_WAIT) ? ~r_write : ~bus.HWRITE;
        w_mem_word = mem[w_rd_idx];
        w_fwd      = (r_state == S_DATA) & r_write & (r_idx == w_rd_idx);
        for (int b = 0; b < 4; b++) begin
            w_rd_word[8*b +: 8] = (w_fwd & r_lanes[b]) ? bus.HWDATA[8*b +: 8]
                                                       : w_mem_word[8*b +: 8];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_state  <= S_IDLE;
            r_wcnt   <= 4'd0;
            r_idx    <= '0;
            r_lanes  <= 4'd0;
            r_write  <= 1'b0;
            r_hrdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= w_wcnt_next;
            if (w_accept) begin
                r_idx   <= w_idx;
                r_lanes <= w_lanes;
                r_write <= bus.HWRITE;
            end
            if ((w_next == S_DATA) && w_rd_read) begin
                r_hrdata <= w_rd_word;
            end else if (w_next == S_ERR2) begin
                r_hrdata <= 32'd0;
            end
        end
    end

    // DATA always lasts exactly one cycle, so every edge seen in DATA is the
    // one that ends it. Reset forces IDLE, which drops a pending write.
    always_ff @(posedge HCLK) begin
        if ((r_state == S_DATA) && r_write) begin
            for (int b = 0; b < 4; b++) begin
                if (r_lanes[b]) begin
                    mem[r_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    assign bus.HRDATA    = r_hrdata;
    assign bus.HREADYOUT = (r_state != S_WAIT) && (r_state != S_ERR1);
`ifdef AHB_SLV_ERR_EN
    assign bus.HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
`else
    assign bus.HRESP     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_sram_slave
//  Description : Bench for ahb_sram_slave. Two instances (zero and three
//                wait states) share one pipelined AHB master model; the
//                phase variable selects which one receives transfers. A
//                byte-addressed memory model predicts every response.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_sram_slave;

    localparam int c_DEPTH = 64;
    localparam int c_WS_B  = 3;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        phase;
    logic        d_sel, d_write, d_lock;
    logic [1:0]  d_trans;
    logic [2:0]  d_size, d_burst;
    logic [3:0]  d_prot;
    logic [31:0] d_addr, d_wdata;

    int   n_pass   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] mdl [2][c_DEPTH*4];
    txn_t q[$];

    always #5 clk = ~clk;

    ahb_sram_slave_if if0();
    ahb_sram_slave_if if3();

    assign if0.HSEL = d_sel & ~phase;   assign if3.HSEL = d_sel & phase;
    assign if0.HADDR = d_addr;          assign if3.HADDR = d_addr;
    assign if0.HWRITE = d_write;        assign if3.HWRITE = d_write;
    assign if0.HTRANS = d_trans;        assign if3.HTRANS = d_trans;
    assign if0.HSIZE = d_size;          assign if3.HSIZE = d_size;
    assign if0.HBURST = d_burst;        assign if3.HBURST = d_burst;
    assign if0.HPROT = d_prot;          assign if3.HPROT = d_prot;
    assign if0.HMASTLOCK = d_lock;      assign if3.HMASTLOCK = d_lock;
    assign if0.HWDATA = d_wdata;        assign if3.HWDATA = d_wdata;
    assign if0.HREADY = if0.HREADYOUT;  assign if3.HREADY = if3.HREADYOUT;

    ahb_sram_slave #(.DEPTH(c_DEPTH), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETN(rst_n), .bus(if0.slave));
    ahb_sram_slave #(.DEPTH(c_DEPTH), .WAIT_STATES(c_WS_B)) u_dut3 (
        .HCLK(clk), .HRESETN(rst_n), .bus(if3.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] sz);
        if (sz == 3'd0) return 1;
        if (sz == 3'd1) return 2;
        return 4;
    endfunction

    function automatic bit exp_err(input logic [31:0] a, input logic [2:0] sz);
        bit e;
        e = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00)
            || (a >= 32'(c_DEPTH*4));
`ifndef AHB_SLV_ERR_EN
        e = 1'b0;
`endif
        return e;
    endfunction

    task automatic mdl_write(input int p, input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] d);
        int n, base, b;
        n    = nbytes(sz);
        base = int'(a & 32'(c_DEPTH*4 - 1));
        base = base - (base % n);
        for (int k = 0; k < n; k++) begin
            b = base + k;
            mdl[p][b] = d[8*(b % 4) +: 8];
        end
    endtask

    function automatic logic [31:0] mdl_read(input int p, input logic [31:0] a);
        int base;
        base = int'(a & 32'(c_DEPTH*4 - 1));
        base = base - (base % 4);
        return {mdl[p][base+3], mdl[p][base+2], mdl[p][base+1], mdl[p][base]};
    endfunction

    function automatic txn_t mk(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                                input logic [31:0] d);
        txn_t t;
        t.sel = 1'b1; t.trans = 2'b10; t.wr = wr; t.addr = a; t.size = sz; t.data = d;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.sel = ($urandom_range(0, 15) != 0);
        case ($urandom_range(0, 15))
            0, 1:    t.trans = 2'b00;
            2:       t.trans = 2'b01;
            default: t.trans = 2'($urandom_range(2, 3));
        endcase
        t.wr   = 1'($urandom_range(0, 1));
        t.size = 3'($urandom_range(0, 3));
        if (t.size == 3'd3) t.size = 3'($urandom_range(2, 7));
        t.addr = 32'($urandom_range(0, c_DEPTH*4 - 1));
        if ($urandom_range(0, 7) == 0) t.addr = $urandom;
        if ($urandom_range(0, 1) == 1) t.addr = t.addr & ~32'(nbytes(t.size) - 1);
        t.data = $urandom;
        return t;
    endfunction

    // ---------------- pipelined master ----------------
    // Entered and left at posedge+1. Address phase of the next transfer
    // overlaps the data phase of the current one; both advance on HREADY.
    task automatic run();
        txn_t ap, dp;
        bit   ap_v = 0, dp_v = 0, e;
        int   lows = 0, cyc = 0, exp_ws;
        logic r, rs;
        logic [31:0] rd;
        exp_ws = phase ? c_WS_B : 0;
        while (q.size() > 0 || ap_v || dp_v) begin
            if (!ap_v && q.size() > 0) begin
                ap   = q.pop_front();
                ap_v = 1;
            end
            d_sel   = ap_v ? ap.sel : 1'b0;
            d_trans = ap_v ? ap.trans : 2'b00;
            d_write = ap_v ? ap.wr : 1'b0;
            d_addr  = ap_v ? ap.addr : $urandom;
            d_size  = ap_v ? ap.size : 3'd2;
            d_burst = 3'($urandom_range(0, 7));
            d_prot  = 4'($urandom_range(0, 15));
            d_lock  = 1'($urandom_range(0, 1));
            d_wdata = (dp_v && dp.wr) ? dp.data : $urandom;
            @(negedge clk);
            r  = phase ? if3.HREADYOUT : if0.HREADYOUT;
            rs = phase ? if3.HRESP     : if0.HRESP;
            rd = phase ? if3.HRDATA    : if0.HRDATA;
            if (dp_v) begin
                e = exp_err(dp.addr, dp.size);
                if (r !== 1'b1) begin
                    lows++;
                    chk("resp_during_wait", 32'(rs), 32'(e));
                    if (lows > 20) begin
                        $display("FAIL timeout: HREADYOUT low %0d cycles", lows);
                        $fatal(1);
                    end
                end else begin
                    chk("wait_cycles", lows, e ? 1 : exp_ws);
                    chk("resp", 32'(rs), 32'(e));
                    if (e)              chk("err_rdata", rd, 32'd0);
                    else if (dp.wr)     mdl_write(int'(phase), dp.addr, dp.size, dp.data);
                    else                chk("rdata", rd, mdl_read(int'(phase), dp.addr));
                    dp_v = 0;
                    lows = 0;
                end
            end else begin
                chk("idle_okay", 32'({r, rs}), 32'b10);
            end
            cyc++;
            if (cyc > 20000) begin
                $display("FAIL timeout: master loop exceeded cycle budget");
                $fatal(1);
            end
            @(posedge clk);
            #1;
            if (r === 1'b1 && ap_v) begin
                if (ap.sel && ap.trans[1]) begin
                    dp   = ap;
                    dp_v = 1;
                end
                ap_v = 0;
            end
        end
        d_sel   = 1'b0;
        d_trans = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0; phase = 1'b0;
        d_sel = 1'b0; d_trans = 2'b00; d_write = 1'b0; d_addr = 32'd0; d_size = 3'd2;
        d_burst = 3'd0; d_prot = 4'd0; d_lock = 1'b0; d_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 32'(if0.HREADYOUT), 32'd1);
        chk("rst_resp0",  32'(if0.HRESP),     32'd0);
        chk("rst_rdata0", if0.HRDATA,         32'd0);
        chk("rst_ready3", 32'(if3.HREADYOUT), 32'd1);
        chk("rst_rdata3", if3.HRDATA,         32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- zero-wait instance ----
        for (int w = 0; w < c_DEPTH; w++) q.push_back(mk(1, 32'(w*4), 3'd2, $urandom));
        run();
        q.push_back(mk(1, 32'h10, 3'd2, 32'hDEADBEEF));
        q.push_back(mk(0, 32'h10, 3'd2, 32'h0));
        q.push_back(mk(1, 32'h20, 3'd2, 32'h0));
        q.push_back(mk(1, 32'h21, 3'd0, 32'h0000AA00));
        q.push_back(mk(1, 32'h22, 3'd1, 32'h12340000));
        q.push_back(mk(0, 32'h20, 3'd2, 32'h0));
        q.push_back(mk(1, 32'h30, 3'd2, 32'h11112222));
        q.push_back(mk(1, 32'h32, 3'd1, 32'hCAFE0000));
        q.push_back(mk(0, 32'h30, 3'd2, 32'h0));
        q.push_back(mk(1, 32'h40, 3'd2, 32'h0BADF00D));
        q.push_back(mk(1, 32'h41, 3'd2, 32'h77777777));
        q.push_back(mk(0, 32'h40, 3'd2, 32'h0));
        q.push_back(mk(0, 32'(c_DEPTH*4 + 8), 3'd2, 32'h0));
        run();
        for (int i = 0; i < 400; i++) q.push_back(rand_txn());
        run();

        // ---- three-wait instance ----
        phase = 1'b1;
        for (int w = 0; w < c_DEPTH; w++) q.push_back(mk(1, 32'(w*4), 3'd2, $urandom));
        run();
        q.push_back(mk(0, 32'h10, 3'd2, 32'h0));
        q.push_back(mk(1, 32'h14, 3'd1, 32'hBEEF5A5A));
        q.push_back(mk(0, 32'h14, 3'd2, 32'h0));
        q.push_back(mk(1, 32'h41, 3'd2, 32'h66666666));
        q.push_back(mk(0, 32'h40, 3'd2, 32'h0));
        run();
        for (int i = 0; i < 120; i++) q.push_back(rand_txn());
        run();

        // Reset during the wait states of a pending write.
        q.push_back(mk(1, 32'h08, 3'd2, 32'hA5A50F0F));
        q.push_back(mk(0, 32'h08, 3'd2, 32'h0));
        run();
        d_sel = 1'b1; d_trans = 2'b10; d_write = 1'b1; d_addr = 32'h08; d_size = 3'd2;
        @(negedge clk);
        chk("rst_pre_ready", 32'(if3.HREADYOUT), 32'd1);
        @(posedge clk); #1;
        d_sel = 1'b0; d_trans = 2'b00; d_wdata = 32'h12345678;
        @(negedge clk);
        chk("rst_in_wait", 32'(if3.HREADYOUT), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 32'(if3.HREADYOUT), 32'd1);
        chk("async_rst_resp",  32'(if3.HRESP),     32'd0);
        chk("async_rst_rdata", if3.HRDATA,         32'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        q.push_back(mk(0, 32'h08, 3'd2, 32'h0));
        run();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
